gf256_div_seq: RTL and testbench



---
 rtl/gf256_div_seq.sv | 164 ++++++++++++++++
 tb/tb_gf256_div_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf256_div_seq.sv
// Sequential GF(2^8) divider: q = a * b^-1, with b^-1 evaluated as b^254 by square-and-multiply.
// A single combinational field multiplier is shared by the SQR, MUL and FINAL states.
module gf256_div_seq #(
   parameter logic [7:0] POLY = 8'h1B
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       inv_only,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       busy,
   output logic       done,
   output logic [7:0] q,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {
      IDLE,
      SQR,
      MUL,
      FINAL
   } stateT;

   stateT      r_state;
   stateT      w_nextState;

   logic [7:0] r_x;
   logic [7:0] r_acc;
   logic [7:0] r_aOp;
   logic       r_bZero;
   logic [2:0] r_step;
   logic [7:0] r_q;
   logic       r_divByZero;
   logic       r_done;

   logic [7:0] w_mulA;
   logic [7:0] w_mulB;
   logic [7:0] w_mulOut;
   logic [7:0] w_partial;
   logic [7:0] w_shifted;

   // Operand steering for the shared multiplier: x*x, acc*x, then acc*a.
   always_comb begin
      w_mulA = r_x;
      w_mulB = r_x;
      case (r_state)
         SQR: begin
            w_mulA = r_x;
            w_mulB = r_x;
         end
         MUL: begin
            w_mulA = r_acc;
            w_mulB = r_x;
         end
         FINAL: begin
            w_mulA = r_acc;
            w_mulB = r_aOp;
         end
         default: begin
            w_mulA = r_x;
            w_mulB = r_x;
         end
      endcase
   end

   // Shift-and-add multiply; each doubling of the running term is reduced by POLY.
   always_comb begin
      w_partial = 8'h00;
      w_shifted = w_mulA;
      for (int k = 0; k < 8; k++) begin
         if (w_mulB[k]) begin
            w_partial = w_partial ^ w_shifted;
         end
         w_shifted = {w_shifted[6:0], 1'b0} ^ (w_shifted[7] ? POLY : 8'h00);
      end
      w_mulOut = w_partial;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = SQR;
            end
         end
         SQR: begin
            w_nextState = MUL;
         end
         MUL: begin
            if (r_step == 3'd7) begin
               w_nextState = FINAL;
            end else begin
               w_nextState = SQR;
            end
         end
         FINAL: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Operands are latched only on acceptance, so input changes while busy are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x         <= 8'h00;
         r_acc       <= 8'h00;
         r_aOp       <= 8'h00;
         r_bZero     <= 1'b0;
         r_step      <= 3'd0;
         r_q         <= 8'h00;
         r_divByZero <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_aOp   <= inv_only ? 8'h01 : a;
                  r_x     <= b;
                  r_acc   <= 8'h01;
                  r_bZero <= (b == 8'h00);
                  r_step  <= 3'd1;
               end
            end
            SQR: begin
               r_x <= w_mulOut;
            end
            MUL: begin
               r_acc <= w_mulOut;
               if (r_step != 3'd7) begin
                  r_step <= r_step + 3'd1;
               end
            end
            FINAL: begin
               r_q         <= w_mulOut;
               r_divByZero <= r_bZero;
               r_done      <= 1'b1;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign q           = r_q;
   assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_gf256_div_seq.sv
// Directed self-checking bench for gf256_div_seq: known inverses/quotients, busy discipline,
// back-to-back issue, mid-operation reset and a sweep of every nonzero divisor.
module tb_gf256_div_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       invOnly;
   logic [7:0] aIn;
   logic [7:0] bIn;
   logic       busy;
   logic       done;
   logic [7:0] q;
   logic       divByZero;

   int checks;
   int failures;

   gf256_div_seq #(.POLY(8'h1B)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .inv_only(invOnly),
      .a(aIn),
      .b(bIn),
      .busy(busy),
      .done(done),
      .q(q),
      .div_by_zero(divByZero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Carry-less 15-bit product followed by long-division reduction by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gfMulModel(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] prod;
      prod = 15'h0;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) prod = prod ^ (15'(x) << i);
      end
      for (int j = 14; j >= 8; j--) begin
         if (prod[j]) prod = prod ^ (15'h11B << (j - 8));
      end
      return prod[7:0];
   endfunction

   // Issues one operation from a post-edge slot; lat = cycles from start sampling to done, -1 on timeout.
   task automatic runOp(input logic [7:0] ia, input logic [7:0] ib, input logic iinv, output int lat);
      aIn = ia;
      bIn = ib;
      invOnly = iinv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      invOnly = 1'b0;
      aIn = 8'h00;
      bIn = 8'h00;
      #2;
      checks++;
      if ({busy, done, q, divByZero} !== 11'h000) begin
         failures++;
         $display("[TB] FAIL reset_outputs got busy=%b done=%b q=%h dz=%b want all zero", busy, done, q, divByZero);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_inverse();
      int lat;
      runOp(8'h77, 8'h53, 1'b1, lat);
      checks++;
      if (lat !== 15) begin
         failures++;
         $display("[TB] FAIL inv53_latency got %0d want 15", lat);
      end
      checks++;
      if (q !== 8'hCA || divByZero !== 1'b0) begin
         failures++;
         $display("[TB] FAIL inv53_q got q=%h dz=%b want q=ca dz=0", q, divByZero);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL inv53_busy_in_done got %b want 0", busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_one_cycle got %b want 0", done);
      end
      runOp(8'h00, 8'h01, 1'b1, lat);
      checks++;
      if (lat !== 15 || q !== 8'h01) begin
         failures++;
         $display("[TB] FAIL inv01 got lat=%0d q=%h want lat=15 q=01", lat, q);
      end
   endtask

   task automatic test_division();
      int lat;
      runOp(8'hC1, 8'h83, 1'b0, lat);
      checks++;
      if (lat !== 15 || q !== 8'h57 || divByZero !== 1'b0) begin
         failures++;
         $display("[TB] FAIL div_c1_83 got lat=%0d q=%h dz=%b want lat=15 q=57 dz=0", lat, q, divByZero);
      end
      runOp(8'h57, 8'h01, 1'b0, lat);
      checks++;
      if (lat !== 15 || q !== 8'h57) begin
         failures++;
         $display("[TB] FAIL div_57_01 got lat=%0d q=%h want lat=15 q=57", lat, q);
      end
      aIn = 8'hFF;
      bIn = 8'h10;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (q !== 8'h57 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL q_held got q=%h busy=%b want q=57 busy=0", q, busy);
      end
   endtask

   task automatic test_zero_divisor();
      int lat;
      runOp(8'h3C, 8'h00, 1'b0, lat);
      checks++;
      if (lat !== 15 || q !== 8'h00 || divByZero !== 1'b1) begin
         failures++;
         $display("[TB] FAIL div_by_zero got lat=%0d q=%h dz=%b want lat=15 q=00 dz=1", lat, q, divByZero);
      end
      runOp(8'h02, 8'h02, 1'b0, lat);
      checks++;
      if (lat !== 15 || q !== 8'h01 || divByZero !== 1'b0) begin
         failures++;
         $display("[TB] FAIL after_zero got lat=%0d q=%h dz=%b want lat=15 q=01 dz=0", lat, q, divByZero);
      end
   endtask

   task automatic test_busy_ignore();
      int doneCount;
      int doneAt;
      logic [7:0] qAtDone;
      doneCount = 0;
      doneAt = -1;
      qAtDone = 8'h00;
      aIn = 8'h00;
      bIn = 8'h53;
      invOnly = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL busy_after_start got %b want 1", busy);
      end
      for (int k = 1; k <= 35; k++) begin
         if (k == 5) begin
            start = 1'b1;
            aIn = 8'hFF;
            bIn = 8'h07;
            invOnly = 1'b0;
         end else if (k == 6) begin
            start = 1'b0;
            bIn = 8'h00;
         end
         @(posedge clk);
         #1;
         if (done) begin
            doneCount++;
            doneAt = k;
            qAtDone = q;
         end
      end
      checks++;
      if (doneCount !== 1 || doneAt !== 15 || qAtDone !== 8'hCA) begin
         failures++;
         $display("[TB] FAIL busy_ignore got dones=%0d at=%0d q=%h want dones=1 at=15 q=ca", doneCount, doneAt, qAtDone);
      end
   endtask

   task automatic test_back_to_back();
      int doneCycles[$];
      int overlap;
      overlap = 0;
      aIn = 8'h00;
      bIn = 8'h53;
      invOnly = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 1; k <= 47; k++) begin
         @(posedge clk);
         #1;
         if (done) doneCycles.push_back(k);
         if (busy === done) overlap++;
         if (k == 47) start = 1'b0;
      end
      checks++;
      if (doneCycles.size() !== 3) begin
         failures++;
         $display("[TB] FAIL b2b_done_count got %0d want 3", doneCycles.size());
      end else begin
         checks++;
         if (doneCycles[0] !== 15 || doneCycles[1] !== 31 || doneCycles[2] !== 47) begin
            failures++;
            $display("[TB] FAIL b2b_done_cycles got %0d,%0d,%0d want 15,31,47", doneCycles[0], doneCycles[1], doneCycles[2]);
         end
      end
      checks++;
      if (overlap !== 0) begin
         failures++;
         $display("[TB] FAIL b2b_busy_eq_not_done got %0d bad cycles want 0", overlap);
      end
      checks++;
      if (q !== 8'hCA) begin
         failures++;
         $display("[TB] FAIL b2b_q got %h want ca", q);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int strayDone;
      strayDone = 0;
      aIn = 8'h00;
      bIn = 8'h53;
      invOnly = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, q, divByZero} !== 11'h000) begin
         failures++;
         $display("[TB] FAIL reset_mid got busy=%b done=%b q=%h dz=%b want all zero", busy, done, q, divByZero);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) strayDone++;
      end
      checks++;
      if (strayDone !== 0) begin
         failures++;
         $display("[TB] FAIL reset_no_done got %0d active cycles want 0", strayDone);
      end
      runOp(8'h00, 8'h53, 1'b1, lat);
      checks++;
      if (lat !== 15 || q !== 8'hCA) begin
         failures++;
         $display("[TB] FAIL after_reset got lat=%0d q=%h want lat=15 q=ca", lat, q);
      end
   endtask

   task automatic test_exhaustive();
      int lat;
      logic [7:0] aRand;
      for (int bv = 1; bv < 256; bv++) begin
         runOp(8'h00, 8'(bv), 1'b1, lat);
         checks++;
         if (lat !== 15 || gfMulModel(q, 8'(bv)) !== 8'h01 || divByZero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sweep_inv b=%h got lat=%0d q=%h q*b=%h want lat=15 q*b=01", bv[7:0], lat, q, gfMulModel(q, 8'(bv)));
         end
         aRand = 8'($urandom_range(0, 255));
         runOp(aRand, 8'(bv), 1'b0, lat);
         checks++;
         if (lat !== 15 || gfMulModel(q, 8'(bv)) !== aRand || divByZero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sweep_div a=%h b=%h got lat=%0d q*b=%h want lat=15 q*b=%h", aRand, bv[7:0], lat, gfMulModel(q, 8'(bv)), aRand);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_inverse();
      test_division();
      test_zero_divisor();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_exhaustive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
